// File: rtl/memory_pkg.sv
// Shared constants for the Y86-64 data-memory stage: instruction codes and
// default memory geometry.
package memory_pkg;

  localparam int MEM_BYTES  = 1024;
  localparam int WORD_BYTES = 8;

  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

endpackage

// File: rtl/memory_data_mem.sv
// Byte-addressed storage with asynchronous clear, one little-endian word
// write port and one combinational word read port.
module data_mem #(
  parameter int MEM_BYTES  = 1024,
  parameter int WORD_BYTES = 8,
  parameter int AW         = $clog2(MEM_BYTES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [8*WORD_BYTES-1:0] wdata,
  input  logic [AW-1:0]           raddr,
  output logic [8*WORD_BYTES-1:0] rdata
);

  logic [7:0] mem_r [MEM_BYTES];

  // Byte array: cleared by reset, whole word committed on the clock edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (we) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        if (({1'b0, waddr} + (AW+1)'(k)) < (AW+1)'(MEM_BYTES)) begin
          mem_r[waddr + AW'(k)] <= wdata[8*k +: 8];
        end
      end
    end
  end

  // Combinational little-endian gather; bytes beyond the array read as zero
  always_comb begin
    rdata = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (({1'b0, raddr} + (AW+1)'(k)) < (AW+1)'(MEM_BYTES)) begin
        rdata[8*k +: 8] = mem_r[raddr + AW'(k)];
      end else begin
        rdata[8*k +: 8] = 8'h00;
      end
    end
  end

endmodule

// File: rtl/memory.sv
// Y86-64 memory stage: selects address and data from the instruction code,
// flags out-of-range addresses and gates the storage accordingly.
module memory
  import memory_pkg::*;
#(
  parameter int MEM_BYTES  = memory_pkg::MEM_BYTES,
  parameter int WORD_BYTES = memory_pkg::WORD_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic [63:0] valM,
  output logic        dmem_error
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - WORD_BYTES);

  logic        rd_en_s;
  logic        wr_en_s;
  logic        err_s;
  logic [63:0] addr_s;
  logic [63:0] wdata_s;
  logic [63:0] rdata_s;

  // Instruction decode into access type, address and write data
  always_comb begin
    rd_en_s = 1'b0;
    wr_en_s = 1'b0;
    addr_s  = 64'd0;
    wdata_s = 64'd0;
    case (icode)
      IMRMOVQ: begin
        rd_en_s = 1'b1;
        addr_s  = valE;
      end
      IRET, IPOPQ: begin
        rd_en_s = 1'b1;
        addr_s  = valA;
      end
      IRMMOVQ, IPUSHQ: begin
        wr_en_s = 1'b1;
        addr_s  = valE;
        wdata_s = valA;
      end
      ICALL: begin
        wr_en_s = 1'b1;
        addr_s  = valE;
        wdata_s = valP;
      end
      default: begin
        rd_en_s = 1'b0;
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Full 64-bit compare so huge addresses never alias into the array
  always_comb begin
    if ((rd_en_s || wr_en_s) && (addr_s > LAST_ADDR)) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // Read data is forced to zero unless a valid read is in progress
  always_comb begin
    if (rd_en_s && !err_s) begin
      valM = rdata_s;
    end else begin
      valM = 64'd0;
    end
  end

  assign dmem_error = err_s;

  data_mem #(
    .MEM_BYTES (MEM_BYTES),
    .WORD_BYTES(WORD_BYTES)
  ) u_data_mem (
    .clk  (clk),
    .reset(reset),
    .we   (wr_en_s && !err_s),
    .waddr(addr_s[AW-1:0]),
    .wdata(wdata_s),
    .raddr(addr_s[AW-1:0]),
    .rdata(rdata_s)
  );

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: byte-array reference model, per-cycle
// compare on the falling edge, directed scenarios plus randomized traffic.
module tb_memory;

  logic        clk;
  logic        reset;
  logic [3:0]  icode;
  logic [63:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic [63:0] valM;
  logic        dmem_error;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model [1024];

  memory dut (
    .clk       (clk),
    .reset     (reset),
    .icode     (icode),
    .valE      (valE),
    .valA      (valA),
    .valP      (valP),
    .valM      (valM),
    .dmem_error(dmem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_rd(input logic [3:0] ic);
    return (ic == 4'd5) || (ic == 4'd9) || (ic == 4'd11);
  endfunction

  function automatic bit is_wr(input logic [3:0] ic);
    return (ic == 4'd4) || (ic == 4'd8) || (ic == 4'd10);
  endfunction

  function automatic logic [63:0] addr_of(input logic [3:0] ic, input logic [63:0] e,
                                          input logic [63:0] a);
    return (ic == 4'd9 || ic == 4'd11) ? a : e;
  endfunction

  function automatic bit err_of(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a);
    return (is_rd(ic) || is_wr(ic)) && (addr_of(ic, e, a) > 64'd1016);
  endfunction

  function automatic logic [63:0] exp_valm(input logic [3:0] ic, input logic [63:0] e,
                                           input logic [63:0] a);
    logic [63:0] v;
    logic [63:0] ad;
    v = 64'd0;
    ad = addr_of(ic, e, a);
    if (is_rd(ic) && !err_of(ic, e, a)) begin
      for (int b = 0; b < 8; b++) v = v + (64'(model[ad + 64'(b)]) << (8 * b));
    end
    return v;
  endfunction

  // Reference storage update
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) model[i] = 8'd0;
    end else if (is_wr(icode) && !err_of(icode, valE, valA)) begin
      for (int b = 0; b < 8; b++)
        model[valE + 64'(b)] = 8'((icode == 4'd8 ? valP : valA) >> (8 * b));
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    logic [63:0] ev;
    logic        ee;
    ev = exp_valm(icode, valE, valA);
    ee = err_of(icode, valE, valA);
    checks++;
    if (valM !== ev) begin
      failures++;
      $display("FAIL model_valM t=%0t icode=%0h valE=%0d valA=%0d got=%h want=%h",
               $time, icode, valE, valA, valM, ev);
    end
    checks++;
    if (dmem_error !== ee) begin
      failures++;
      $display("FAIL model_err t=%0t icode=%0h valE=%0d valA=%0d got=%b want=%b",
               $time, icode, valE, valA, dmem_error, ee);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic put(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                     input logic [63:0] p);
    icode = ic;
    valE  = e;
    valA  = a;
    valP  = p;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] r;
    reset = 1'b1;
    put(4'd0, 64'd0, 64'd0, 64'd0);
    #3;
    chk("reset_valM", valM, 64'd0);
    chk("reset_err", {63'd0, dmem_error}, 64'd0);
    put(4'd4, 64'd100, 64'd77, 64'd0);
    tick;
    reset = 1'b0;
    put(4'd5, 64'd100, 64'd0, 64'd0);
    #3; chk("reset_blocks_write", valM, 64'd0);
    tick;

    // Scenario 1
    put(4'd4, 64'd100, 64'd49, 64'd0); tick;
    put(4'd5, 64'd100, 64'd0, 64'd0); #3;
    chk("s1_valM", valM, 64'd49);
    chk("s1_err", {63'd0, dmem_error}, 64'd0);
    tick;

    // Scenario 2
    put(4'd4, 64'd250, -64'sd49, 64'd0); tick;
    put(4'd5, 64'd250, 64'd0, 64'd0); #3;
    chk("s2_neg", valM, -64'sd49);
    tick;
    put(4'd4, 64'd100, 64'd99, 64'd0); #3;
    chk("s2_old_before_edge", valM, 64'd0);
    tick;
    put(4'd5, 64'd100, 64'd0, 64'd0); #3;
    chk("s2_valM", valM, 64'd99);
    tick;
    put(4'd5, 64'd99, 64'd0, 64'd0); #3;
    chk("s2_unaligned", valM, 64'd99 << 8);
    tick;

    // Scenario 3
    put(4'd8, 64'd82, 64'd0, 64'd87); tick;
    put(4'd9, 64'd0, 64'd82, 64'd0); #3;
    chk("s3_ret", valM, 64'd87);
    tick;
    put(4'd11, 64'd0, 64'd82, 64'd0); #3;
    chk("s3_pop", valM, 64'd87);
    tick;

    // Scenario 4
    put(4'd4, 64'd1020, 64'd5, 64'd0); #3;
    chk("s4_err", {63'd0, dmem_error}, 64'd1);
    tick;
    put(4'd5, 64'd1016, 64'd0, 64'd0); #3;
    chk("s4_edge_valM", valM, 64'd0);
    chk("s4_edge_err", {63'd0, dmem_error}, 64'd0);
    tick;
    put(4'd5, 64'd1017, 64'd0, 64'd0); #3;
    chk("s4_over_err", {63'd0, dmem_error}, 64'd1);
    tick;
    put(4'd11, 64'd0, 64'hFFFF_FFFF_FFFF_FC00, 64'd0); #3;
    chk("s4_huge_err", {63'd0, dmem_error}, 64'd1);
    tick;

    // Scenario 5
    put(4'd4, 64'd200, 64'd49, 64'd0); tick;
    put(4'd5, 64'd200, 64'd0, 64'd0); #1;
    chk("s5_before", valM, 64'd49);
    reset = 1'b1; #1;
    chk("s5_cleared", valM, 64'd0);
    reset = 1'b0; #1;
    tick;

    // Scenario 6
    put(4'd0, 64'd100, 64'd55, 64'd55); #3;
    chk("s6_valM", valM, 64'd0);
    chk("s6_err", {63'd0, dmem_error}, 64'd0);
    tick;
    put(4'd5, 64'd100, 64'd0, 64'd0); #3;
    chk("s6_no_write", valM, 64'd0);
    tick;

    // Randomized traffic over a small window plus the top boundary
    for (int n = 0; n < 400; n++) begin
      logic [63:0] ad;
      logic [3:0]  ic;
      ic = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: ad = 64'($urandom_range(0, 40));
        1: ad = 64'($urandom_range(1000, 1023));
        2: ad = {$urandom, $urandom};
        default: ad = 64'($urandom_range(0, 1023));
      endcase
      r = {$urandom, $urandom};
      if (ic == 4'd9 || ic == 4'd11) put(ic, r, ad, {$urandom, $urandom});
      else put(ic, ad, r, {$urandom, $urandom});
      if ($urandom_range(0, 60) == 0) begin
        #2; reset = 1'b1; #1; reset = 1'b0;
      end
      tick;
    end

    put(4'd0, 64'd0, 64'd0, 64'd0);
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
